// File: rtl/serial_pattern_tx_if.sv
// serial_pattern_tx_if: start handshake, pattern fields and serial stream of serial_pattern_tx
interface serial_pattern_tx_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic [GAP_W-1:0] gap;
  logic             abort;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sent_cnt;
  modport master (output start, pattern, repeat_n, gap, abort,
                  input x, x_valid, busy, done, sent_cnt);
  modport slave  (input start, pattern, repeat_n, gap, abort,
                  output x, x_valid, busy, done, sent_cnt);
endinterface

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: serializes a latched pattern MSB-first, repeated with zero-gap bits between repetitions
module serial_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input logic clk,
  input logic rst,
  serial_pattern_tx_if.slave bus
);
  localparam int IW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IW-1:0] LAST = IW'(PAT_W - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP, FIN} state_t;
  state_t state;
  logic [PAT_W-1:0] sr;
  logic [IW-1:0] idx;
  logic [CNT_W-1:0] rep_left, sent_cnt;
  logic [GAP_W-1:0] gap_len, gcnt;
  logic x, x_valid, busy, done;
  assign bus.x = x;
  assign bus.x_valid = x_valid;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.sent_cnt = sent_cnt;
  // Outputs are registered one state ahead: each branch loads what the next cycle shows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      idx <= '0;
      rep_left <= '0;
      gap_len <= '0;
      gcnt <= '0;
      sent_cnt <= '0;
      x <= 1'b0;
      x_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          sr <= bus.pattern;
          rep_left <= bus.repeat_n;
          gap_len <= bus.gap;
          sent_cnt <= '0;
          idx <= LAST;
          x <= bus.pattern[PAT_W-1] & (bus.repeat_n != '0);
          x_valid <= bus.repeat_n != '0;
          busy <= bus.repeat_n != '0;
          done <= bus.repeat_n == '0;
          state <= (bus.repeat_n != '0) ? SHIFT : FIN;
        end
        SHIFT: if (bus.abort) begin
          state <= IDLE;
          x <= 1'b0;
          x_valid <= 1'b0;
          busy <= 1'b0;
        end else if (idx != '0) begin
          idx <= idx - 1'b1;
          x <= sr[idx - 1'b1];
        end else begin
          sent_cnt <= (&sent_cnt) ? sent_cnt : sent_cnt + 1'b1;
          rep_left <= rep_left - 1'b1;
          if (rep_left == CNT_W'(1)) begin
            state <= FIN;
            x <= 1'b0;
            x_valid <= 1'b0;
            busy <= 1'b0;
            done <= 1'b1;
          end else if (gap_len != '0) begin
            state <= GAP;
            gcnt <= gap_len;
            x <= 1'b0;
          end else begin
            idx <= LAST;
            x <= sr[PAT_W-1];
          end
        end
        GAP: if (bus.abort) begin
          state <= IDLE;
          x_valid <= 1'b0;
          busy <= 1'b0;
        end else if (gcnt == GAP_W'(1)) begin
          state <= SHIFT;
          idx <= LAST;
          x <= sr[PAT_W-1];
        end else begin
          gcnt <= gcnt - 1'b1;
        end
        default: begin
          done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: directed scenario tests for serial_pattern_tx with a 1101 overlapping detector
module tb_serial_pattern_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  serial_pattern_tx_if bus ();
  serial_pattern_tx dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int z_cnt = 0;
  logic [3:0] hist = 4'b0;
  // Overlapping 1101 Moore detector fed by the stream; z is hist==1101
  always @(posedge clk) begin
    hist <= bus.x_valid ? {hist[2:0], bus.x} : 4'b0;
    if (hist == 4'b1101) z_cnt <= z_cnt + 1;
  end

  task automatic launch(input logic [3:0] p, input logic [3:0] r, input logic [3:0] g);
    @(negedge clk);
    bus.pattern = p;
    bus.repeat_n = r;
    bus.gap = g;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic test_reset;
    bus.start = 0; bus.pattern = 0; bus.repeat_n = 0; bus.gap = 0; bus.abort = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.x, bus.x_valid, bus.busy, bus.done} !== 4'b0000) begin
      errors++; $display("FAIL reset_outs: got %b expected 0000", {bus.x, bus.x_valid, bus.busy, bus.done});
    end
    checks++;
    if (bus.sent_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_sent_cnt: got %0d expected 0", bus.sent_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.x_valid, bus.busy, bus.done} !== 3'b000) begin
      errors++; $display("FAIL idle_after_reset: got %b expected 000", {bus.x_valid, bus.busy, bus.done});
    end
  endtask

  task automatic test_single;
    logic [3:0] e = 4'b1101;
    launch(4'b1101, 4'd1, 4'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.x, bus.x_valid, bus.busy, bus.done} !== {e[4-k], 3'b110}) begin
        errors++; $display("FAIL single_bit%0d: got %b expected %b", k, {bus.x, bus.x_valid, bus.busy, bus.done}, {e[4-k], 3'b110});
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.x, bus.x_valid, bus.busy, bus.done, bus.sent_cnt} !== {4'b0001, 4'd1}) begin
      errors++; $display("FAIL single_done: got %b/%0d expected 0001/1", {bus.x, bus.x_valid, bus.busy, bus.done}, bus.sent_cnt);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++; $display("FAIL single_done_pulse: got %b expected 0", bus.done);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] e = 4'b0101;
    launch(4'b1101, 4'd1, 4'd0);
    repeat (5) @(negedge clk);
    checks++;
    if (bus.done !== 1'b1) begin
      errors++; $display("FAIL b2b_first_done: got %b expected 1", bus.done);
    end
    bus.pattern = 4'b0101; bus.repeat_n = 4'd1; bus.gap = 4'd0; bus.start = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.x_valid, bus.busy, bus.done} !== 3'b000) begin
      errors++; $display("FAIL b2b_start_in_fin: got %b expected 000", {bus.x_valid, bus.busy, bus.done});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if ({bus.x, bus.x_valid, bus.busy} !== {e[3-k], 2'b11}) begin
        errors++; $display("FAIL b2b_bit%0d: got %b expected %b", k, {bus.x, bus.x_valid, bus.busy}, {e[3-k], 2'b11});
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.done, bus.sent_cnt} !== {1'b1, 4'd1}) begin
      errors++; $display("FAIL b2b_second_done: got %b/%0d expected 1/1", bus.done, bus.sent_cnt);
    end
  endtask

  task automatic test_loopback;
    logic [11:0] e = 12'b110111011101;
    int z0;
    z0 = z_cnt;
    launch(4'b1101, 4'd3, 4'd0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.x, bus.x_valid, bus.busy} !== {e[12-k], 2'b11}) begin
        errors++; $display("FAIL loop_bit%0d: got %b expected %b", k, {bus.x, bus.x_valid, bus.busy}, {e[12-k], 2'b11});
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.x_valid, bus.busy, bus.done, bus.sent_cnt} !== {3'b001, 4'd3}) begin
      errors++; $display("FAIL loop_done: got %b/%0d expected 001/3", {bus.x_valid, bus.busy, bus.done}, bus.sent_cnt);
    end
    @(negedge clk);
    checks++;
    if (z_cnt - z0 !== 3) begin
      errors++; $display("FAIL loop_detect_count: got %0d expected 3", z_cnt - z0);
    end
  endtask

  task automatic test_gap;
    logic [9:0] e = 10'b1101001101;
    launch(4'b1101, 4'd2, 4'd2);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.x, bus.x_valid, bus.busy} !== {e[10-k], 2'b11}) begin
        errors++; $display("FAIL gap_bit%0d: got %b expected %b", k, {bus.x, bus.x_valid, bus.busy}, {e[10-k], 2'b11});
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.x_valid, bus.busy, bus.done, bus.sent_cnt} !== {3'b001, 4'd2}) begin
      errors++; $display("FAIL gap_done: got %b/%0d expected 001/2", {bus.x_valid, bus.busy, bus.done}, bus.sent_cnt);
    end
  endtask

  task automatic test_zero;
    launch(4'b1011, 4'd0, 4'd3);
    @(negedge clk);
    checks++;
    if ({bus.x, bus.x_valid, bus.busy, bus.done, bus.sent_cnt} !== {4'b0001, 4'd0}) begin
      errors++; $display("FAIL zero_done: got %b/%0d expected 0001/0", {bus.x, bus.x_valid, bus.busy, bus.done}, bus.sent_cnt);
    end
    @(negedge clk);
    checks++;
    if ({bus.x_valid, bus.busy, bus.done} !== 3'b000) begin
      errors++; $display("FAIL zero_after: got %b expected 000", {bus.x_valid, bus.busy, bus.done});
    end
  endtask

  task automatic test_abort;
    logic [6:0] e = 7'b1101011;
    launch(4'b1101, 4'd3, 4'd1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.x, bus.x_valid, bus.busy} !== {e[7-k], 2'b11}) begin
        errors++; $display("FAIL abort_bit%0d: got %b expected %b", k, {bus.x, bus.x_valid, bus.busy}, {e[7-k], 2'b11});
      end
      if (k == 3) begin bus.start = 1'b1; bus.pattern = 4'b0010; end
      if (k == 4) bus.start = 1'b0;
      if (k == 7) bus.abort = 1'b1;
    end
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if ({bus.x, bus.x_valid, bus.busy, bus.done, bus.sent_cnt} !== {4'b0000, 4'd1}) begin
      errors++; $display("FAIL abort_idle: got %b/%0d expected 0000/1", {bus.x, bus.x_valid, bus.busy, bus.done}, bus.sent_cnt);
    end
    for (int k = 9; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.x_valid, bus.done, bus.sent_cnt} !== {2'b00, 4'd1}) begin
        errors++; $display("FAIL abort_no_done%0d: got %b/%0d expected 00/1", k, {bus.x_valid, bus.done}, bus.sent_cnt);
      end
    end
  endtask

  task automatic test_rst_gap;
    logic [4:0] e = 5'b10110;
    logic [3:0] f = 4'b1001;
    launch(4'b1011, 4'd2, 4'd3);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.x, bus.x_valid} !== {e[5-k], 1'b1}) begin
        errors++; $display("FAIL rst_pre_bit%0d: got %b expected %b", k, {bus.x, bus.x_valid}, {e[5-k], 1'b1});
      end
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.x, bus.x_valid, bus.busy, bus.done, bus.sent_cnt} !== 8'd0) begin
      errors++; $display("FAIL rst_async: got %b/%0d expected 0000/0", {bus.x, bus.x_valid, bus.busy, bus.done}, bus.sent_cnt);
    end
    @(negedge clk);
    checks++;
    if ({bus.x_valid, bus.busy, bus.done} !== 3'b000) begin
      errors++; $display("FAIL rst_hold: got %b expected 000", {bus.x_valid, bus.busy, bus.done});
    end
    rst = 1'b0;
    launch(4'b1001, 4'd1, 4'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.x, bus.x_valid, bus.busy} !== {f[4-k], 2'b11}) begin
        errors++; $display("FAIL rst_post_bit%0d: got %b expected %b", k, {bus.x, bus.x_valid, bus.busy}, {f[4-k], 2'b11});
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.done, bus.sent_cnt} !== {1'b1, 4'd1}) begin
      errors++; $display("FAIL rst_post_done: got %b/%0d expected 1/1", bus.done, bus.sent_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_loopback;
    test_gap;
    test_zero;
    test_abort;
    test_rst_gap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
